// File: rtl/vga_timing_gen_if.sv
// vga_tim timing bus: counts, sync and blanking flags for the whole draw pipeline.
// With VGA_TIMING_FRAME_CNT_EN defined the bus also carries frame_cnt and sof.
interface vga_timing_gen_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        sof;
`endif

    modport master (
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        output frame_cnt,
        output sof
`endif
    );

    modport slave (
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input hblnk,
        input vblnk
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        input frame_cnt,
        input sof
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: source of the vga_tim bus. Default 800x600@60 Hz (40 MHz pixel rate).
// Optional feature macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter and a
// one-cycle start-of-frame strobe on the bus.
// Every output is a flop; flags are decoded from the next count values so they always
// describe the count presented in the same cycle.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    vga_timing_gen_if.master  tim
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries in 11-bit unsigned form; totals above 2047 cannot be represented.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        line_end;
    logic        frame_end;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        sof_q, sof_d;
`endif

    // Next raster position: advance one pixel per enabled clock, wrapping line and frame.
    always_comb begin
        line_end  = (hcount_q == H_LAST);
        frame_end = line_end && (vcount_q == V_LAST);
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        if (pix_en) begin
            if (line_end) begin
                hcount_d = 11'd0;
                if (frame_end) begin
                    vcount_d = 11'd0;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
    end

    // Flags decoded from the next counts; holding counts therefore also hold the flags,
    // and vertical flags can only move when vcount moves, i.e. when hcount returns to 0.
    always_comb begin
        hblnk_d = (hcount_d >= H_BLNK_BEG);
        vblnk_d = (vcount_d >= V_BLNK_BEG);
        hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
        vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Start-of-frame strobe and frame counter step on the edge that wraps to (0,0).
    always_comb begin
        sof_d       = pix_en && frame_end;
        frame_cnt_d = frame_cnt_q;
        if (sof_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end
`endif

    // Timing registers; reset wins over pix_en and restarts the frame at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= SYNC_OFF;
            vsync_q  <= SYNC_OFF;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame statistics registers; cleared by reset, so no strobe comes out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
            sof_q       <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            sof_q       <= sof_d;
        end
    end

    assign tim.frame_cnt = frame_cnt_q;
    assign tim.sof       = sof_q;
`endif

    assign tim.hcount = hcount_q;
    assign tim.vcount = vcount_q;
    assign tim.hsync  = hsync_q;
    assign tim.vsync  = vsync_q;
    assign tim.hblnk  = hblnk_q;
    assign tim.vblnk  = vblnk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default SVGA instance (positive sync) and a small-raster
// instance (25x16, negative sync) share clk/rst/pix_en. The reference model tracks each
// raster as a single linear pixel position and derives all outputs arithmetically.
module tb_vga_timing_gen;

    localparam int DH_A = 800, DH_FP = 40, DH_S = 128, DH_BP = 88;
    localparam int DV_A = 600, DV_FP = 1,  DV_S = 4,   DV_BP = 23;
    localparam int DH_T = DH_A + DH_FP + DH_S + DH_BP;
    localparam int DV_T = DV_A + DV_FP + DV_S + DV_BP;
    localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;
    localparam int SV_A = 10, SV_FP = 1, SV_S = 2, SV_BP = 3;
    localparam int SH_T = SH_A + SH_FP + SH_S + SH_BP;
    localparam int SV_T = SV_A + SV_FP + SV_S + SV_BP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    bit   chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    vga_timing_gen_if tim_def ();
    vga_timing_gen_if tim_sml ();

    vga_timing_gen u_def (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .tim    (tim_def.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_A), .H_FP (SH_FP), .H_SYNC (SH_S), .H_BP (SH_BP),
        .V_ACTIVE (SV_A), .V_FP (SV_FP), .V_SYNC (SV_S), .V_BP (SV_BP),
        .SYNC_POL (1'b0)
    ) u_sml (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .tim    (tim_sml.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: linear position within the frame.
    int pos_def = 0;
    int pos_sml = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    int  fr_def = 0, fr_sml = 0;
    bit  sof_def = 0, sof_sml = 0;
    int  fc_offset = 0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            pos_def = 0;
            pos_sml = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            fr_def = 0; fr_sml = 0; sof_def = 0; sof_sml = 0;
`endif
        end else if (pix_en) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            sof_def = (pos_def == DH_T * DV_T - 1);
            sof_sml = (pos_sml == SH_T * SV_T - 1);
            if (sof_def) fr_def++;
            if (sof_sml) fr_sml++;
`endif
            pos_def = (pos_def + 1) % (DH_T * DV_T);
            pos_sml = (pos_sml + 1) % (SH_T * SV_T);
        end else begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            sof_def = 0; sof_sml = 0;
`endif
        end
    end

    function automatic bit in_win(input int c, input int lo, input int len);
        return (c >= lo) && (c < lo + len);
    endfunction

    task automatic check_raster(input string tag, input int pos,
                                input int ha, input int hfp, input int hs, input int ht,
                                input int va, input int vfp, input int vs, input bit pol,
                                input logic [10:0] hc, input logic [10:0] vc,
                                input logic hsy, input logic vsy, input logic hb, input logic vb);
        int h, v;
        h = pos % ht;
        v = pos / ht;
        check({tag, ".hcount"}, hc, h);
        check({tag, ".vcount"}, vc, v);
        check({tag, ".hblnk"}, hb, (h >= ha) ? 1 : 0);
        check({tag, ".vblnk"}, vb, (v >= va) ? 1 : 0);
        check({tag, ".hsync"}, hsy, in_win(h, ha + hfp, hs) ? pol : !pol);
        check({tag, ".vsync"}, vsy, in_win(v, va + vfp, vs) ? pol : !pol);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_raster("def", pos_def, DH_A, DH_FP, DH_S, DH_T, DV_A, DV_FP, DV_S, 1'b1,
                         tim_def.hcount, tim_def.vcount, tim_def.hsync, tim_def.vsync,
                         tim_def.hblnk, tim_def.vblnk);
            check_raster("sml", pos_sml, SH_A, SH_FP, SH_S, SH_T, SV_A, SV_FP, SV_S, 1'b0,
                         tim_sml.hcount, tim_sml.vcount, tim_sml.hsync, tim_sml.vsync,
                         tim_sml.hblnk, tim_sml.vblnk);
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("def.sof", tim_def.sof, sof_def);
            check("sml.sof", tim_sml.sof, sof_sml);
            check("def.frame_cnt", tim_def.frame_cnt, 16'(fr_def));
            check("sml.frame_cnt", tim_sml.frame_cnt, 16'(fc_offset + fr_sml));
`endif
        end
    end

    initial begin
        int sof_seen;
        // Reset held for 3 clocks; (0,0) is presented while held.
        rst = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst.def.hcount", tim_def.hcount, 0);
        check("rst.def.hsync", tim_def.hsync, 0);
        check("rst.sml.hsync", tim_sml.hsync, 1);
        check("rst.sml.vsync", tim_sml.vsync, 1);
        check("rst.def.hblnk", tim_def.hblnk, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("rst.sml.sof", tim_sml.sof, 0);
`endif

        // Free run with pix_en high: after k edges both rasters sit at position k.
        rst = 1'b0;
        pix_en = 1'b1;
        sof_seen = 0;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            case (k)
                1:    begin check("lit.def.h1", tim_def.hcount, 1); check("lit.def.v1", tim_def.vcount, 0); end
                17:   check("lit.sml.hsync17", tim_sml.hsync, 1);
                18:   check("lit.sml.hsync18", tim_sml.hsync, 0);
                21:   check("lit.sml.hsync21", tim_sml.hsync, 0);
                22:   check("lit.sml.hsync22", tim_sml.hsync, 1);
                249:  check("lit.sml.vblnk249", tim_sml.vblnk, 0);
                250:  check("lit.sml.vblnk250", tim_sml.vblnk, 1);
                274:  check("lit.sml.vsync274", tim_sml.vsync, 1);
                275:  check("lit.sml.vsync275", tim_sml.vsync, 0);
                324:  check("lit.sml.vsync324", tim_sml.vsync, 0);
                325:  check("lit.sml.vsync325", tim_sml.vsync, 1);
                399:  begin check("lit.sml.h399", tim_sml.hcount, 24); check("lit.sml.v399", tim_sml.vcount, 15); end
                400:  begin check("lit.sml.h400", tim_sml.hcount, 0); check("lit.sml.v400", tim_sml.vcount, 0); end
                799:  check("lit.def.hblnk799", tim_def.hblnk, 0);
                800:  check("lit.def.hblnk800", tim_def.hblnk, 1);
                839:  check("lit.def.hsync839", tim_def.hsync, 0);
                840:  check("lit.def.hsync840", tim_def.hsync, 1);
                967:  check("lit.def.hsync967", tim_def.hsync, 1);
                968:  check("lit.def.hsync968", tim_def.hsync, 0);
                1055: begin check("lit.def.h1055", tim_def.hcount, 1055); check("lit.def.v1055", tim_def.vcount, 0); end
                1056: begin check("lit.def.h1056", tim_def.hcount, 0); check("lit.def.v1056", tim_def.vcount, 1); end
                default: ;
            endcase
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (tim_sml.sof) begin
                sof_seen++;
                check("lit.sml.sof_h", tim_sml.hcount, 0);
                check("lit.sml.sof_v", tim_sml.vcount, 0);
            end
`endif
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("lit.sml.sof_count", sof_seen, 3);
        check("lit.sml.frame_cnt3", tim_sml.frame_cnt, 3);
`endif

        // pix_en pattern 1,0,0,1 starting at hcount=10.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pix_en = 1'b1;
        repeat (10) @(negedge clk);
        check("lit.hold.h10", tim_def.hcount, 10);
        @(negedge clk);
        check("lit.hold.e1", tim_def.hcount, 11);
        pix_en = 1'b0;
        @(negedge clk);
        check("lit.hold.e2", tim_def.hcount, 11);
        @(negedge clk);
        check("lit.hold.e3", tim_def.hcount, 11);
        check("lit.hold.hblnk", tim_def.hblnk, 0);
        pix_en = 1'b1;
        @(negedge clk);
        check("lit.hold.e4", tim_def.hcount, 12);

        // Mid-frame reset: small raster at (12,12), inside vsync.
        repeat (300) @(negedge clk);
        check("lit.mid.sml_v", tim_sml.vcount, 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("lit.mid.h0", tim_sml.hcount, 0);
        check("lit.mid.v0", tim_sml.vcount, 0);
        check("lit.mid.vsync", tim_sml.vsync, 1);
        check("lit.mid.vblnk", tim_sml.vblnk, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("lit.mid.frame_cnt", tim_sml.frame_cnt, 0);
`endif
        @(negedge clk);
        check("lit.mid.restart", tim_sml.hcount, 1);

        // Randomized pix_en with occasional resets.
        for (int i = 0; i < 40000; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;

`ifdef VGA_TIMING_FRAME_CNT_EN
        // Preload the small frame counter to all-ones; it must wrap to 0 at the next sof.
        pix_en = 1'b1;
        @(posedge clk);
        #2;
        force u_sml.frame_cnt_q = 16'hFFFF;
        #1;
        release u_sml.frame_cnt_q;
        fc_offset = 16'hFFFF - fr_sml;
        sof_seen = 0;
        for (int k = 0; k < SH_T * SV_T + 2; k++) begin
            @(negedge clk);
            if (tim_sml.sof && sof_seen == 0) begin
                sof_seen++;
                check("lit.wrap.frame_cnt", tim_sml.frame_cnt, 0);
            end
        end
        check("lit.wrap.sof_seen", sof_seen, 1);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
